// File: rtl/tx_serializer.sv
// Serializes a captured payload of 1..DATA_W/8 bytes to a byte-wide UART port,
// either as raw bytes or as uppercase ASCII hex characters.
module tx_serializer #(
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] dout_tx,
    input  logic [1:0]        type_tx,
    input  logic              hex_tx,
    input  logic              req_tx,
    input  logic              rdy_tx,
    output logic              vld_tx,
    output logic [7:0]        d_tx,
    output logic              ack_tx,
    output logic              busy_tx
);

    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(2 * NB + 1);

    typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hex_q, hex_d;
    logic [CW-1:0]     nbytes_q, nbytes_d;
    logic [CW-1:0]     nchar_q, nchar_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic [7:0]        dtx_q, dtx_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    // Size decode is done in int width so the clamp happens before truncation.
    function automatic logic [CW-1:0] size_bytes(input logic [1:0] t);
        int unsigned n;
        case (t)
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = NB;
        endcase
        if (n > NB) n = NB;
        return CW'(n);
    endfunction

    function automatic logic [7:0] char_at(input logic [DATA_W-1:0] data,
                                           input logic              hex,
                                           input logic [CW-1:0]     nbytes,
                                           input logic [CW-1:0]     idx);
        logic [CW-1:0] b;
        logic [7:0]    byte_v;
        logic [3:0]    nib;
        if (hex) begin
            b      = nbytes - CW'(1) - (idx >> 1);
            byte_v = 8'(data >> {b, 3'b000});
            nib    = idx[0] ? byte_v[3:0] : byte_v[7:4];
            return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end
        b = (BIG_ENDIAN != 0) ? (nbytes - CW'(1) - idx) : idx;
        return 8'(data >> {b, 3'b000});
    endfunction

    // The first character is computed from the capture values so vld_tx can
    // rise in the very first SEND cycle while all outputs stay registered.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        hex_d    = hex_q;
        nbytes_d = nbytes_q;
        nchar_d  = nchar_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        dtx_d    = dtx_q;
        ack_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_tx) begin
                    data_d   = dout_tx;
                    hex_d    = hex_tx;
                    nbytes_d = size_bytes(type_tx);
                    nchar_d  = hex_tx ? (nbytes_d << 1) : nbytes_d;
                    cnt_d    = nchar_d;
                    vld_d    = 1'b1;
                    dtx_d    = char_at(data_d, hex_d, nbytes_d, '0);
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (rdy_tx) begin
                    if (cnt_q == CW'(1)) begin
                        cnt_d   = '0;
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        dtx_d = char_at(data_q, hex_q, nbytes_q, nchar_q - cnt_d);
                    end
                end
            end
            ACK: state_d = HOLD;
            HOLD: begin
                if (!req_tx) state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            hex_q    <= 1'b0;
            nbytes_q <= '0;
            nchar_q  <= '0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            dtx_q    <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            hex_q    <= hex_d;
            nbytes_q <= nbytes_d;
            nchar_q  <= nchar_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            dtx_q    <= dtx_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign vld_tx  = vld_q;
    assign d_tx    = dtx_q;
    assign ack_tx  = ack_q;
    assign busy_tx = busy_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Four serializer variants (32 LE, 32 BE, 64 LE, 8 LE) driven in parallel and
// compared against a string/arithmetic model of the expected character stream.
module tb_tx_serializer;

    localparam int DWS[4] = '{32, 32, 64, 8};
    localparam int BES[4] = '{0, 1, 0, 0};

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] dout;
    logic [1:0]  type_tx;
    logic        hex_tx;
    logic        req;
    logic        rdy;
    logic        vld[4];
    logic [7:0]  dq[4];
    logic        ack[4];
    logic        busy[4];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  got[4][$];
    int          acks[4];
    logic        stall_q[4];
    logic [7:0]  dprev[4];
    logic [63:0] exp_data;
    logic [1:0]  exp_typ;
    logic        exp_hex;

    always #5 clk = ~clk;

    tx_serializer #(.DATA_W(32), .BIG_ENDIAN(0)) u_le32 (
        .clk(clk), .rstn(rstn), .dout_tx(dout[31:0]), .type_tx(type_tx), .hex_tx(hex_tx),
        .req_tx(req), .rdy_tx(rdy), .vld_tx(vld[0]), .d_tx(dq[0]), .ack_tx(ack[0]), .busy_tx(busy[0]));
    tx_serializer #(.DATA_W(32), .BIG_ENDIAN(1)) u_be32 (
        .clk(clk), .rstn(rstn), .dout_tx(dout[31:0]), .type_tx(type_tx), .hex_tx(hex_tx),
        .req_tx(req), .rdy_tx(rdy), .vld_tx(vld[1]), .d_tx(dq[1]), .ack_tx(ack[1]), .busy_tx(busy[1]));
    tx_serializer #(.DATA_W(64), .BIG_ENDIAN(0)) u_le64 (
        .clk(clk), .rstn(rstn), .dout_tx(dout), .type_tx(type_tx), .hex_tx(hex_tx),
        .req_tx(req), .rdy_tx(rdy), .vld_tx(vld[2]), .d_tx(dq[2]), .ack_tx(ack[2]), .busy_tx(busy[2]));
    tx_serializer #(.DATA_W(8), .BIG_ENDIAN(0)) u_le8 (
        .clk(clk), .rstn(rstn), .dout_tx(dout[7:0]), .type_tx(type_tx), .hex_tx(hex_tx),
        .req_tx(req), .rdy_tx(rdy), .vld_tx(vld[3]), .d_tx(dq[3]), .ack_tx(ack[3]), .busy_tx(busy[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_n(input int dw, input logic [1:0] typ);
        int n;
        n = (typ == 2'b11) ? dw / 8 : (1 << typ);
        if (n > dw / 8) n = dw / 8;
        return n;
    endfunction

    function automatic logic [7:0] exp_char(input int dw, input int be, input logic [63:0] data,
                                            input logic [1:0] typ, input logic hx, input int k);
        int          n;
        logic [63:0] t;
        string       digits;
        digits = "0123456789ABCDEF";
        n = exp_n(dw, typ);
        if (!hx) begin
            t = data >> (8 * ((be != 0) ? (n - 1 - k) : k));
            return t[7:0];
        end
        t = data >> (4 * (2 * n - 1 - k));
        return digits.getc(int'(t[3:0]));
    endfunction

    function automatic bit all_acked();
        for (int i = 0; i < 4; i++) if (acks[i] < 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit any_busy();
        for (int i = 0; i < 4; i++) if (busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Collects transfers and checks hold-under-backpressure on every variant.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rstn === 1'b1) begin
                if (stall_q[i]) begin
                    check($sformatf("hold_vld%0d", i), 64'(vld[i]), 64'(1));
                    check($sformatf("hold_d%0d", i), 64'(dq[i]), 64'(dprev[i]));
                end
                if (vld[i] && rdy) got[i].push_back(dq[i]);
                if (ack[i]) acks[i]++;
                stall_q[i] = vld[i] && !rdy;
                dprev[i]   = dq[i];
            end else begin
                stall_q[i] = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int c = 0;
        while (any_busy() && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        check("idle_timeout", 64'(c < 60), 64'(1));
    endtask

    task automatic begin_txn(input logic [63:0] data, input logic [1:0] typ, input logic hx);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            got[i].delete();
            acks[i] = 0;
        end
        exp_data = data;
        exp_typ  = typ;
        exp_hex  = hx;
        dout     = data;
        type_tx  = typ;
        hex_tx   = hx;
        req      = 1'b1;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            int n;
            n = exp_n(DWS[i], exp_typ) * (exp_hex ? 2 : 1);
            check($sformatf("count%0d", i), 64'(got[i].size()), 64'(n));
            for (int k = 0; k < n && k < got[i].size(); k++)
                check($sformatf("char%0d_%0d", i, k), 64'(got[i][k]),
                      64'(exp_char(DWS[i], BES[i], exp_data, exp_typ, exp_hex, k)));
            check($sformatf("acks%0d", i), 64'(acks[i]), 64'(1));
        end
    endtask

    task automatic end_txn(input bit rnd, input int drop_at);
        int cyc = 0;
        while (!all_acked() && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (rnd) begin
                dout    = {$urandom, $urandom};
                type_tx = 2'($urandom);
                hex_tx  = 1'($urandom);
                rdy     = 1'($urandom_range(0, 1));
            end
            if (cyc >= drop_at) req = 1'b0;
        end
        check("ack_timeout", 64'(cyc < 400), 64'(1));
        req = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int c;
        rstn = 1'b0; req = 1'b0; rdy = 1'b0; dout = '0; type_tx = '0; hex_tx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acks[i] = 0; stall_q[i] = 1'b0; dprev[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_vld%0d", i), 64'(vld[i]), 64'(0));
            check($sformatf("rst_d%0d", i), 64'(dq[i]), 64'(0));
            check($sformatf("rst_ack%0d", i), 64'(ack[i]), 64'(0));
            check($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'(0));
        end
        rstn = 1'b1;

        // Directed vectors: binary word, hex byte, wide hex, clamped size.
        rdy = 1'b1;
        begin_txn(64'h44332211, 2'b10, 1'b0); end_txn(0, 1000);
        begin_txn(64'h000000A7, 2'b00, 1'b1); end_txn(0, 1000);
        begin_txn(64'h0123456789ABCDEF, 2'b11, 1'b1); end_txn(0, 1000);
        begin_txn(64'hFEDCBA9876543210, 2'b11, 1'b0); end_txn(0, 1000);

        // Backpressure on the first character of a two-byte request.
        rdy = 1'b0;
        begin_txn(64'h1234BEEF, 2'b01, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_vld", 64'(vld[0]), 64'(1));
            check("bp_d", 64'(dq[0]), 64'(8'hEF));
        end
        @(posedge clk); #1;
        rdy = 1'b1;
        end_txn(0, 1000);

        // Request held long after completion.
        begin_txn(64'h3C, 2'b00, 1'b0);
        c = 0;
        while (acks[0] < 1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("held_ack_timeout", 64'(c < 50), 64'(1));
        repeat (20) begin
            @(posedge clk); #1;
            check("held_busy", 64'(busy[0]), 64'(1));
        end
        for (int i = 0; i < 4; i++) check($sformatf("held_acks%0d", i), 64'(acks[i]), 64'(1));
        req = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) check($sformatf("held_idle%0d", i), 64'(busy[i]), 64'(0));
        compare_all();

        // Reset after the second transfer, then a request in the release cycle.
        begin_txn(64'h44332211, 2'b10, 1'b0);
        c = 0;
        while (got[0].size() < 2 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("rst_mid_reach", 64'(got[0].size()), 64'(2));
        rstn = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_vld%0d", i), 64'(vld[i]), 64'(0));
            check($sformatf("midrst_ack%0d", i), 64'(ack[i]), 64'(0));
            check($sformatf("midrst_busy%0d", i), 64'(busy[i]), 64'(0));
        end
        req  = 1'b0;
        rstn = 1'b1;
        begin_txn(64'h5A, 2'b00, 1'b0);
        @(posedge clk); #1;
        check("release_vld", 64'(vld[0]), 64'(1));
        check("release_d", 64'(dq[0]), 64'(8'h5A));
        end_txn(0, 1000);

        // Random payloads, sizes, modes, backpressure, early req drop, input churn.
        for (int t = 0; t < 30; t++) begin
            rdy = 1'($urandom_range(0, 1));
            begin_txn({$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end_txn(1, $urandom_range(1, 20));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_serializer.md
TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the payload width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter BIG_ENDIAN, default 0; 0 sends binary bytes LSB-byte first, 1 sends them MSB-byte first.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port dout_tx  input  DATA_W  the payload to transmit.
REQ-006 SHALL have port type_tx  input  2  the size code: 00=1 byte, 01=2 bytes, 10=4 bytes, 11=DATA_W/8 bytes.
REQ-007 SHALL have port hex_tx  input  1  0 selects raw binary bytes; 1 selects ASCII hex characters.
REQ-008 SHALL have port req_tx  input  1  the level request from the producer.
REQ-009 SHALL have port rdy_tx  input  1  the UART transmitter can accept a byte this cycle.
REQ-010 SHALL have port vld_tx  output  1  d_tx holds a valid byte.
REQ-011 SHALL have port d_tx  output  8  the byte offered to the UART.
REQ-012 SHALL have port ack_tx  output  1  a one-cycle pulse marking request completion.
REQ-013 SHALL have port busy_tx  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement a state machine with states IDLE, SEND, ACK and HOLD; all outputs SHALL be registered.
REQ-015 IDLE with req_tx=1 SHALL capture dout_tx, type_tx and hex_tx into internal registers, load the character count, and enter SEND on the next cycle.
REQ-016 Byte count SHALL be N=1/2/4/DATA_W/8 per type_tx, clamped to DATA_W/8 when the coded size exceeds it.
REQ-017 Character count SHALL be N when hex_tx=0 and 2N when hex_tx=1.
REQ-018 vld_tx SHALL rise in the first SEND cycle, which is one cycle after capture.
REQ-019 A character SHALL transfer on any cycle with vld_tx=1 and rdy_tx=1.
REQ-020 After a transfer, the next character SHALL appear on d_tx in the following cycle, with vld_tx held high, so that back-to-back transfers proceed at one per cycle.
REQ-021 While vld_tx=1 and rdy_tx=0, d_tx and vld_tx SHALL remain unchanged.
REQ-022 In binary mode, bytes are taken from the low N bytes of the captured payload, ordered LSB-first, or MSB-first when BIG_ENDIAN=1.
REQ-023 In hex mode, characters are taken over the low N bytes, always most-significant nibble first, regardless of BIG_ENDIAN.
REQ-024 Hex nibble encoding: 0-9 map to 8'h30-8'h39, and A-F map to 8'h41-8'h46 (uppercase).
REQ-025 On transfer of the last character, vld_tx SHALL drop in the next cycle and the state SHALL enter ACK.
REQ-026 ACK SHALL assert ack_tx for exactly one cycle, then enter HOLD.
REQ-027 HOLD SHALL wait for req_tx=0, then return to IDLE, so that a single request level never triggers two transmissions.
REQ-028 Changes to dout_tx, type_tx or hex_tx after capture SHALL have no effect on the transfer in progress.
REQ-029 A req_tx drop during SEND SHALL NOT abort the transfer; all characters are sent and ack_tx still pulses.
REQ-030 The character counter SHALL be sized for 2*DATA_W/8 characters without wrap, and SHALL reload only on capture.

Reset
REQ-031 While rstn=0 at a clock edge, the block SHALL reset to: state IDLE, vld_tx=0, d_tx=8'h00, ack_tx=0, busy_tx=0, and counters and captured registers cleared.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer, produce no ack_tx, and leave no partial state, so that after release the block accepts a new request.
REQ-033 req_tx=1 in the cycle rstn is released SHALL be captured on the first active edge.

Verification
REQ-034 Binary word with DATA_W=32: dout_tx=32'h44332211, type_tx=10, hex_tx=0, rdy_tx=1 -> d_tx sequence 11,22,33,44 on consecutive cycles, then one ack_tx pulse; with BIG_ENDIAN=1 the sequence is 44,33,22,11.
REQ-035 Hex byte: dout_tx=32'h000000A7, type_tx=00, hex_tx=1 -> d_tx sequence 8'h41 then 8'h37, then ack_tx.
REQ-036 Backpressure: type_tx=01 with rdy_tx low for 3 cycles while the first byte is offered -> d_tx and vld_tx are held for those cycles, and exactly 2 transfers occur in total.
REQ-037 Held request: req_tx stays 1 for 20 cycles after ack_tx -> exactly one transmission; busy_tx stays high until req_tx falls, then one cycle later the state is IDLE.
REQ-038 Reset mid-word: rstn low after the 2nd transfer -> next cycle vld_tx=0 and ack_tx=0; a new request of 8'h5A with type_tx=00 then transmits 5A correctly.
REQ-039 With DATA_W=64 and type_tx=11 in hex mode -> 16 characters MSB-first; with DATA_W=8 and type_tx=10 -> 1 byte only (clamped).
